// File: rtl/axis_packet_fifo.sv
// axis_packet_fifo: single-clock AXI4-Stream FIFO storing {tstrb, tlast, tdata}.
// C_PACKET_MODE=0 forwards each beat once stored (cut-through); C_PACKET_MODE=1
// holds beats back until the packet's tlast is stored (store-and-forward).
module axis_packet_fifo #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int C_FIFO_DEPTH       = 16,
  parameter int C_PACKET_MODE      = 0
) (
  input  logic                              axis_aclk,
  input  logic                              axis_aresetn,
  // slave (write) side
  output logic                              s00_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
  input  logic                              s00_axis_tlast,
  input  logic                              s00_axis_tvalid,
  // master (read) side
  output logic                              m00_axis_tvalid,
  output logic [C_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                              m00_axis_tlast,
  input  logic                              m00_axis_tready,
  // status
  output logic [$clog2(C_FIFO_DEPTH):0]     fifo_count,
  output logic                              fifo_full,
  output logic                              fifo_empty
);

  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int SW = C_AXIS_TDATA_WIDTH / 8;
  localparam int EW = SW + 1 + C_AXIS_TDATA_WIDTH;
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(C_FIFO_DEPTH);

  // Entry layout: {tstrb, tlast, tdata}
  logic [EW-1:0] r_mem [C_FIFO_DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [AW:0] r_commit_ptr;
  logic        r_rst_done;

  logic [AW:0]   w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_wr_en;
  logic          w_rd_en;
  logic          w_tvalid;
  logic          w_fills;
  logic          w_commit;
  logic [AW:0]   w_wr_ptr_nxt;
  logic [EW-1:0] w_rd_entry;

  // Occupancy and handshake decode
  always_comb begin
    w_count      = r_wr_ptr - r_rd_ptr;
    w_full       = (w_count == DEPTH_L);
    w_empty      = (r_wr_ptr == r_rd_ptr);
    w_wr_ptr_nxt = r_wr_ptr + 1'b1;

    // Write acceptance never looks at the read side: no write while full
    w_wr_en  = s00_axis_tvalid && r_rst_done && !w_full;

    if (C_PACKET_MODE != 0) begin
      w_tvalid = r_rst_done && (r_rd_ptr != r_commit_ptr);
    end else begin
      w_tvalid = r_rst_done && !w_empty;
    end
    w_rd_en = w_tvalid && m00_axis_tready;

    // A write that leaves the FIFO full while nothing is committed would stall
    // both sides forever, so the stored partial packet is released instead.
    w_fills  = w_wr_en && !w_rd_en && (w_count == (DEPTH_L - 1'b1));
    w_commit = w_wr_en && (s00_axis_tlast || (w_fills && (r_commit_ptr == r_rd_ptr)));
  end

  // Pointer and reset-done state
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rst_done   <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      if (w_wr_en) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_commit) begin
        r_commit_ptr <= w_wr_ptr_nxt;
      end
    end
  end

  // Storage array, deliberately not reset
  always_ff @(posedge axis_aclk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {s00_axis_tstrb, s00_axis_tlast, s00_axis_tdata};
    end
  end

  // Head-of-queue entry drives the master side directly
  always_comb begin
    w_rd_entry = r_mem[r_rd_ptr[AW-1:0]];
  end

  assign s00_axis_tready = r_rst_done && !w_full;
  assign m00_axis_tvalid = w_tvalid;
  assign m00_axis_tdata  = w_rd_entry[C_AXIS_TDATA_WIDTH-1:0];
  assign m00_axis_tlast  = w_rd_entry[C_AXIS_TDATA_WIDTH];
  assign m00_axis_tstrb  = w_rd_entry[EW-1:C_AXIS_TDATA_WIDTH+1];
  assign fifo_count      = w_count;
  assign fifo_full       = w_full;
  assign fifo_empty      = w_empty;

endmodule

// File: tb/tb_axis_packet_fifo.sv
// tb_axis_packet_fifo: scoreboard bench covering a cut-through and a
// store-and-forward instance of axis_packet_fifo side by side.
module tb_axis_packet_fifo;

  localparam int W  = 32;
  localparam int SW = 4;
  localparam int D  = 16;
  localparam int CW = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // cut-through instance signals
  logic          ct_s_tready, ct_s_tlast, ct_s_tvalid;
  logic [W-1:0]  ct_s_tdata;
  logic [SW-1:0] ct_s_tstrb;
  logic          ct_m_tvalid, ct_m_tlast, ct_m_tready;
  logic [W-1:0]  ct_m_tdata;
  logic [SW-1:0] ct_m_tstrb;
  logic [CW-1:0] ct_count;
  logic          ct_full, ct_empty;

  // store-and-forward instance signals
  logic          pk_s_tready, pk_s_tlast, pk_s_tvalid;
  logic [W-1:0]  pk_s_tdata;
  logic [SW-1:0] pk_s_tstrb;
  logic          pk_m_tvalid, pk_m_tlast, pk_m_tready;
  logic [W-1:0]  pk_m_tdata;
  logic [SW-1:0] pk_m_tstrb;
  logic [CW-1:0] pk_count;
  logic          pk_full, pk_empty;

  axis_packet_fifo #(
    .C_AXIS_TDATA_WIDTH(W), .C_FIFO_DEPTH(D), .C_PACKET_MODE(0)
  ) u_ct (
    .axis_aclk(clk), .axis_aresetn(rst_n),
    .s00_axis_tready(ct_s_tready), .s00_axis_tdata(ct_s_tdata),
    .s00_axis_tstrb(ct_s_tstrb), .s00_axis_tlast(ct_s_tlast),
    .s00_axis_tvalid(ct_s_tvalid),
    .m00_axis_tvalid(ct_m_tvalid), .m00_axis_tdata(ct_m_tdata),
    .m00_axis_tstrb(ct_m_tstrb), .m00_axis_tlast(ct_m_tlast),
    .m00_axis_tready(ct_m_tready),
    .fifo_count(ct_count), .fifo_full(ct_full), .fifo_empty(ct_empty)
  );

  axis_packet_fifo #(
    .C_AXIS_TDATA_WIDTH(W), .C_FIFO_DEPTH(D), .C_PACKET_MODE(1)
  ) u_pk (
    .axis_aclk(clk), .axis_aresetn(rst_n),
    .s00_axis_tready(pk_s_tready), .s00_axis_tdata(pk_s_tdata),
    .s00_axis_tstrb(pk_s_tstrb), .s00_axis_tlast(pk_s_tlast),
    .s00_axis_tvalid(pk_s_tvalid),
    .m00_axis_tvalid(pk_m_tvalid), .m00_axis_tdata(pk_m_tdata),
    .m00_axis_tstrb(pk_m_tstrb), .m00_axis_tlast(pk_m_tlast),
    .m00_axis_tready(pk_m_tready),
    .fifo_count(pk_count), .fifo_full(pk_full), .fifo_empty(pk_empty)
  );

  int checks = 0;
  int errors = 0;

  logic [SW+W:0] ct_q[$];
  logic [SW+W:0] pk_q[$];
  int ct_rd_cnt = 0;
  int pk_rd_cnt = 0;
  int pk_last_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push accepted beats, pop and compare on each output handshake.
  // Sampled on the falling edge, so the handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ct_s_tvalid && ct_s_tready) ct_q.push_back({ct_s_tstrb, ct_s_tlast, ct_s_tdata});
      if (ct_m_tvalid && ct_m_tready) begin
        ct_rd_cnt++;
        if (ct_q.size() == 0) check("ct_sb_nonempty", 64'(ct_q.size() != 0), 64'd1);
        else check("ct_beat", 64'({ct_m_tstrb, ct_m_tlast, ct_m_tdata}), 64'(ct_q.pop_front()));
      end
      if (pk_s_tvalid && pk_s_tready) pk_q.push_back({pk_s_tstrb, pk_s_tlast, pk_s_tdata});
      if (pk_m_tvalid && pk_m_tready) begin
        pk_rd_cnt++;
        if (pk_m_tlast) pk_last_cnt++;
        if (pk_q.size() == 0) check("pk_sb_nonempty", 64'(pk_q.size() != 0), 64'd1);
        else check("pk_beat", 64'({pk_m_tstrb, pk_m_tlast, pk_m_tdata}), 64'(pk_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nxt;
    int base;
    int lbase;
    int bad;
    int first_cnt;

    ct_s_tvalid = 1'b0; ct_s_tdata = '0; ct_s_tstrb = '0; ct_s_tlast = 1'b0; ct_m_tready = 1'b0;
    pk_s_tvalid = 1'b0; pk_s_tdata = '0; pk_s_tstrb = '0; pk_s_tlast = 1'b0; pk_m_tready = 1'b0;

    // ---- reset and idle ----
    repeat (3) @(posedge clk);
    #1;
    check("rst_tready",  64'(ct_s_tready), 64'd0);
    check("rst_tvalid",  64'(ct_m_tvalid), 64'd0);
    check("rst_count",   64'(ct_count),    64'd0);
    check("rst_empty",   64'(ct_empty),    64'd1);
    check("rst_full",    64'(ct_full),     64'd0);
    check("rst_pk_tvalid", 64'(pk_m_tvalid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_tready_before_edge", 64'(ct_s_tready), 64'd0);
    tick();
    check("rel_ct_tready", 64'(ct_s_tready), 64'd1);
    check("rel_pk_tready", 64'(pk_s_tready), 64'd1);
    check("idle_tvalid",   64'(ct_m_tvalid), 64'd0);
    check("idle_empty",    64'(ct_empty),    64'd1);

    // ---- cut-through fill with reader stalled ----
    nxt = 0;
    for (int c = 0; c < 20; c++) begin
      ct_s_tvalid = 1'b1; ct_s_tdata = 32'(nxt); ct_s_tstrb = 4'(nxt); ct_s_tlast = (nxt % 5 == 4);
      @(negedge clk);
      if (ct_s_tready) nxt++;
      tick();
    end
    check("fill_accepted", 64'(nxt),         64'd16);
    check("fill_full",     64'(ct_full),     64'd1);
    check("fill_count",    64'(ct_count),    64'd16);
    check("fill_tready",   64'(ct_s_tready), 64'd0);
    ct_m_tready = 1'b1;
    for (int c = 0; c < 100 && nxt < 20; c++) begin
      ct_s_tvalid = 1'b1; ct_s_tdata = 32'(nxt); ct_s_tstrb = 4'(nxt); ct_s_tlast = (nxt % 5 == 4);
      @(negedge clk);
      if (ct_s_tready) nxt++;
      tick();
    end
    ct_s_tvalid = 1'b0;
    check("fill_rest_accepted", 64'(nxt), 64'd20);
    for (int c = 0; c < 100 && !ct_empty; c++) tick();
    check("fill_drained", 64'(ct_empty),  64'd1);
    check("fill_reads",   64'(ct_rd_cnt), 64'd20);

    // ---- cut-through continuous streaming ----
    base = ct_rd_cnt;
    bad  = 0;
    for (int k = 0; k < 100; k++) begin
      ct_s_tvalid = 1'b1; ct_s_tdata = 32'h1000 + 32'(k); ct_s_tstrb = 4'(k * 3); ct_s_tlast = (k % 7 == 6);
      tick();
      if (ct_count != 5'd1) bad++;
    end
    check("stream_count_not_1", 64'(bad), 64'd0);
    check("stream_reads", 64'(ct_rd_cnt - base), 64'd99);
    ct_s_tvalid = 1'b0;
    tick(); tick();
    check("stream_empty", 64'(ct_empty), 64'd1);
    check("stream_total", 64'(ct_rd_cnt - base), 64'd100);

    // ---- store-and-forward single packet ----
    pk_m_tready = 1'b1;
    base  = pk_rd_cnt;
    lbase = pk_last_cnt;
    for (int i = 0; i < 5; i++) begin
      pk_s_tvalid = 1'b1; pk_s_tdata = 32'hA0 + 32'(i); pk_s_tstrb = 4'hF; pk_s_tlast = (i == 4);
      tick();
      if (i < 4) check("pk_valid_early", 64'(pk_m_tvalid), 64'd0);
      else       check("pk_valid_on_last", 64'(pk_m_tvalid), 64'd1);
    end
    pk_s_tvalid = 1'b0; pk_s_tlast = 1'b0;
    for (int c = 0; c < 50 && !pk_empty; c++) tick();
    check("pk_reads", 64'(pk_rd_cnt - base), 64'd5);
    check("pk_lasts", 64'(pk_last_cnt - lbase), 64'd1);

    // ---- store-and-forward oversize packet, forced commit ----
    base = pk_rd_cnt;
    nxt = 0;
    first_cnt = -1;
    for (int c = 0; c < 80 && nxt < 19; c++) begin
      pk_s_tvalid = 1'b1; pk_s_tdata = 32'hB00 + 32'(nxt); pk_s_tstrb = 4'(nxt + 1); pk_s_tlast = 1'b0;
      @(negedge clk);
      if (pk_s_tready) nxt++;
      tick();
      if (pk_m_tvalid && first_cnt < 0) first_cnt = int'(pk_count);
    end
    pk_s_tvalid = 1'b0;
    check("big_first_valid_count", 64'(first_cnt), 64'd16);
    repeat (30) tick();
    check("big_forced_reads", 64'(pk_rd_cnt - base), 64'd16);
    check("big_tail_held",    64'(pk_m_tvalid),      64'd0);
    check("big_tail_count",   64'(pk_count),         64'd3);
    pk_s_tvalid = 1'b1; pk_s_tdata = 32'hB00 + 32'd19; pk_s_tstrb = 4'h5; pk_s_tlast = 1'b1;
    tick();
    pk_s_tvalid = 1'b0; pk_s_tlast = 1'b0;
    check("big_tail_released", 64'(pk_m_tvalid), 64'd1);
    for (int c = 0; c < 50 && !pk_empty; c++) tick();
    check("big_total_reads", 64'(pk_rd_cnt - base), 64'd20);

    // ---- asynchronous reset mid-stream ----
    ct_m_tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ct_s_tvalid = 1'b1; ct_s_tdata = 32'h700 + 32'(i); ct_s_tstrb = 4'hA; ct_s_tlast = 1'b0;
      tick();
    end
    ct_s_tvalid = 1'b0;
    check("mid_count",  64'(ct_count),    64'd7);
    check("mid_tvalid", 64'(ct_m_tvalid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tvalid", 64'(ct_m_tvalid), 64'd0);
    check("arst_count",  64'(ct_count),    64'd0);
    check("arst_empty",  64'(ct_empty),    64'd1);
    check("arst_tready", 64'(ct_s_tready), 64'd0);
    ct_q.delete();
    pk_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    base = ct_rd_cnt;
    ct_s_tvalid = 1'b1; ct_s_tdata = 32'h55; ct_s_tstrb = 4'h3; ct_s_tlast = 1'b1;
    tick();
    ct_s_tvalid = 1'b0; ct_s_tlast = 1'b0;
    check("post_rst_count", 64'(ct_count), 64'd1);
    ct_m_tready = 1'b1;
    for (int c = 0; c < 20 && !ct_empty; c++) tick();
    repeat (3) tick();
    check("post_rst_reads", 64'(ct_rd_cnt - base), 64'd1);
    check("post_rst_empty", 64'(ct_empty), 64'd1);

    check("ct_sb_left", 64'(ct_q.size()), 64'd0);
    check("pk_sb_left", 64'(pk_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_packet_fifo.md
Name: axis_packet_fifo

Overview:
Single-clock AXI4-Stream FIFO with parametrised data width and depth. Each entry stores tdata, tstrb and tlast. Supports two modes: cut-through, where a beat is forwarded as soon as it is stored, and store-and-forward, where a packet is held back until its tlast beat is stored. It sits between AXI-Stream producers and consumers in the Zynq PL datapath and replaces fixed-length 16-beat burst buffering with true concurrent read/write buffering.

Parameters:
C_AXIS_TDATA_WIDTH, 32, tdata width in bits; must be a multiple of 8.
C_FIFO_DEPTH, 16, number of entries; must be a power of 2, minimum 2.
C_PACKET_MODE, 0, 0 = cut-through; 1 = store-and-forward.

Ports:
axis_aclk  in  1  single clock for both stream sides.
axis_aresetn  in  1  reset; asynchronous assert, active-low.
s00_axis_tready  out  1  slave ready.
s00_axis_tdata  in  C_AXIS_TDATA_WIDTH  slave data.
s00_axis_tstrb  in  C_AXIS_TDATA_WIDTH/8  slave byte strobes; stored and forwarded unchanged.
s00_axis_tlast  in  1  slave end of packet.
s00_axis_tvalid  in  1  slave valid.
m00_axis_tvalid  out  1  master valid.
m00_axis_tdata  out  C_AXIS_TDATA_WIDTH  master data.
m00_axis_tstrb  out  C_AXIS_TDATA_WIDTH/8  master strobes.
m00_axis_tlast  out  1  master end of packet.
m00_axis_tready  in  1  master ready.
fifo_count  out  clog2(C_FIFO_DEPTH)+1  number of stored beats, 0..C_FIFO_DEPTH.
fifo_full  out  1  fifo_count == C_FIFO_DEPTH.
fifo_empty  out  1  fifo_count == 0.

Behaviour:
- Reset: axis_aresetn low asynchronously clears wr_ptr, rd_ptr, commit_ptr and rst_done.
  - While in reset and before rst_done is set: s00_axis_tready=0, m00_axis_tvalid=0, fifo_count=0, fifo_empty=1, fifo_full=0.
  - rst_done is set on the first axis_aclk edge after reset release, so s00_axis_tready rises 1 cycle after release.
  - Memory contents are not reset.
- Pointers: wr_ptr, rd_ptr and commit_ptr are each clog2(DEPTH)+1 bits; the MSB is a wrap bit.
  - fifo_count = wr_ptr - rd_ptr, modulo 2^(clog2(DEPTH)+1).
  - full when fifo_count == DEPTH; empty when wr_ptr == rd_ptr.
- Write side:
  - s00_axis_tready = rst_done && !full. It does not depend on m00_axis_tready, so there is no write-while-full even when a read happens in the same cycle.
  - wr_en = s00_axis_tvalid && s00_axis_tready. On wr_en, the entry at wr_ptr <= {tstrb, tlast, tdata} and wr_ptr increments, wrapping naturally.
- Read side:
  - m00_axis_tdata, m00_axis_tstrb and m00_axis_tlast are driven combinationally from the entry at rd_ptr.
  - rd_en = m00_axis_tvalid && m00_axis_tready; rd_en increments rd_ptr.
  - While m00_axis_tvalid=1 and m00_axis_tready=0, master outputs hold stable.
- Cut-through (C_PACKET_MODE=0):
  - m00_axis_tvalid = rst_done && !empty.
  - Latency is 1 cycle: a beat written at edge N is valid after edge N.
  - No combinational bypass when empty.
- Store-and-forward (C_PACKET_MODE=1):
  - m00_axis_tvalid = rst_done && (rd_ptr != commit_ptr).
  - commit_ptr <= wr_ptr+1 on a wr_en with tlast=1.
  - Deadlock escape: if a write makes the FIFO full and the committed region is empty, commit_ptr <= wr_ptr+1, forcing a partial-packet commit. Later beats of that packet commit on the next tlast or the next forced commit.
  - Latency: a tlast beat written at edge N makes the whole packet valid after edge N.
- Simultaneous read and write: both pointers move and fifo_count is unchanged. Legal at any non-full, non-empty occupancy.
- Transfers with tlast=0 are never merged, split or reordered; the tlast bit is reproduced exactly.
- Reset asserted mid-packet: stored data is discarded and m00_axis_tvalid drops immediately, asynchronously.

Test Plan:
- Reset then idle: tready=0 during reset and 1 from the 2nd clock after release; tvalid=0, fifo_count=0, fifo_empty=1.
- Cut-through, DEPTH=16, m00_axis_tready=0: write data 0x00..0x13 continuously → exactly 16 accepted, tready=0 at count=16, fifo_full=1. Enable ready → 0x00..0x0F read out in order, then 0x10 accepted.
- Cut-through, continuous tvalid and tready: stream 100 beats → throughput 1 beat/cycle after 1-cycle latency, fifo_count stays at 1 and never exceeds 1.
- Packet mode: write 5 beats 0xA0..0xA4 with tlast on 0xA4, tready held high → m00_axis_tvalid stays 0 until the edge that writes 0xA4; then 5 beats emitted with tlast only on 0xA4.
- Packet mode, DEPTH=16: write a 20-beat packet with no tlast until beat 20 → forced commit at count=16; the first 16 beats are emitted; the remaining 4 are committed on tlast and emitted after it.
- Assert axis_aresetn low mid-stream at count=7 → tvalid=0 asynchronously, count=0. After release, new data 0x55 is emitted first and none of the old entries reappear.
